mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that answers on the core's data-memory port alongside `data_mem`. The core (the bus initiator) writes bytes into a small TX FIFO and polls status; the block serialises them as 8N1 frames (optional parity) on `tx`. This gives bench programs a real byte-stream output in addition to the `verify` word.

---
 rtl/mmio_uart_tx_pkg.sv | 32 +++
 rtl/mmio_uart_tx_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, serializer state encodings and default parameters.
package mmio_defs;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_1000;
    localparam int          DEF_CLK_DIV   = 16;

    localparam logic [3:0] TXDATA_OFF  = 4'h0;
    localparam logic [3:0] STATUS_OFF  = 4'h4;
    localparam logic [3:0] DIVISOR_OFF = 4'h8;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_PARITY    = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    // A divisor of 0 behaves like 1, so every bit lasts at least one clock.
    function automatic logic [15:0] bit_reload(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and 8N1 serializer.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit to every frame.
module mmio_uart_tx
    import mmio_defs::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int          CLK_DIV    = DEF_CLK_DIV,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [1:0]    reg_sel;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_divisor;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]    count4;
    logic          parity_flag;
    logic          unused_bits;

    logic          overflow_reg;
    logic [15:0]   divisor_reg;
    tx_state_t     state_reg, state_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [2:0]    idx_reg, idx_next;
    logic [7:0]    data_reg, data_next;
    logic          tx_reg, tx_next;
    logic          bit_done;

    assign hit        = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel    = addr[3:2];
    assign wr_txdata  = hit && we && (reg_sel == TXDATA_OFF[3:2]);
    assign wr_status  = hit && we && (reg_sel == STATUS_OFF[3:2]);
    assign wr_divisor = hit && we && (reg_sel == DIVISOR_OFF[3:2]);
    assign unused_bits = ^{addr[1:0], data_i[31:16]};

`ifdef MMIO_UART_TX_PARITY_EN
    assign parity_flag = 1'b1;
`else
    assign parity_flag = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            divisor_reg  <= 16'(CLK_DIV);
        end else begin
            if (wr_txdata && fifo_full && !fifo_pop) overflow_reg <= 1'b1;
            else if (wr_status)                      overflow_reg <= 1'b0;
            if (wr_divisor) divisor_reg <= data_i[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            tx_reg    <= tx_next;
        end
    end

    assign bit_done = (cnt_reg == 16'd0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        fifo_pop   = 1'b0;
        tx_next    = 1'b1;

        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    data_next  = fifo_dout;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next = S_DATA;
                    idx_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (idx_reg == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        data_next  = fifo_dout;
                        state_next = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // The divisor is sampled only at bit boundaries, so a mid-bit write
        // never stretches or shortens the bit already on the line.
        if (state_reg == S_IDLE) begin
            if (fifo_pop) cnt_next = bit_reload(divisor_reg);
        end else if (bit_done) begin
            cnt_next = bit_reload(divisor_reg);
        end else begin
            cnt_next = cnt_reg - 16'd1;
        end

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = data_next[idx_next];
            S_PARITY: tx_next = ^data_next;
            default:  tx_next = 1'b1;
        endcase
    end

    assign tx     = tx_reg;
    assign count4 = 4'(fifo_count);

    always_comb begin
        data_o = '0;
        if (hit) begin
            case (reg_sel)
                STATUS_OFF[3:2]: begin
                    data_o[ST_FULL]             = fifo_full;
                    data_o[ST_EMPTY]            = fifo_empty;
                    data_o[ST_BUSY]             = (state_reg != S_IDLE);
                    data_o[ST_OVERFLOW]         = overflow_reg;
                    data_o[ST_COUNT_LSB +: 4]   = count4;
                    data_o[ST_PARITY]           = parity_flag;
                end
                DIVISOR_OFF[3:2]: data_o[15:0] = divisor_reg;
                default:          data_o       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-map vector table, hand-timed
// frame sequences, and randomized bursts checked against a bit-stream model.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

`ifdef MMIO_UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [31:0] PAR_FLAG = PAR_EN ? 32'h100 : 32'h0;
    localparam int FB   = PAR_EN ? 11 : 10;
    localparam int LOGN = 32768;

    localparam logic [31:0] A_TXDATA  = 32'h0000_1000;
    localparam logic [31:0] A_STATUS  = 32'h0000_1004;
    localparam logic [31:0] A_DIVISOR = 32'h0000_1008;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx;

    mmio_uart_tx #(
        .BASE_ADDR  (32'h0000_1000),
        .CLK_DIV    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    logic tx_at [LOGN];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (edge_cnt < LOGN) tx_at[edge_cnt] <= tx;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    logic exp_bits[$];
    int   exp_lens[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic add_vec(input logic c, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] e, input string n);
        vec_t v;
        v.ce = c; v.we = w; v.addr = a; v.wdata = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b0; addr = a;
        #1 d = data_o;
        ce = 1'b0; addr = '0;
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) begin
            @(posedge clk); #1;
        end
    endtask

    // One frame = start 0, 8 data bits LSB first, optional even parity, stop 1.
    task automatic add_frame(input logic [7:0] b, input int len);
        exp_bits.push_back(1'b0); exp_lens.push_back(len);
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(b[i]); exp_lens.push_back(len);
        end
        if (PAR_EN) begin
            exp_bits.push_back(^b); exp_lens.push_back(len);
        end
        exp_bits.push_back(1'b1); exp_lens.push_back(len);
    endtask

    // Compares the logged line from edge start-1 (idle) through the expected
    // bit stream and three trailing idle clocks.
    task automatic check_wave(input string name, input int start);
        int total = 0;
        int t;
        int bad = -1;
        logic bad_got = 1'b0;
        logic bad_exp = 1'b0;
        for (int k = 0; k < exp_bits.size(); k++) total += exp_lens[k];
        wait_edge(start + total + 4);
        if (tx_at[start-1] !== 1'b1) begin
            bad = -1 + 0; bad_got = tx_at[start-1]; bad_exp = 1'b1;
            bad = 0 - 1;
        end
        t = start;
        for (int k = 0; k < exp_bits.size(); k++) begin
            for (int j = 0; j < exp_lens[k]; j++) begin
                if (tx_at[t] !== exp_bits[k] && bad < 0) begin
                    bad = t - start; bad_got = tx_at[t]; bad_exp = exp_bits[k];
                end
                t++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (tx_at[t] !== 1'b1 && bad < 0) begin
                bad = t - start; bad_got = tx_at[t]; bad_exp = 1'b1;
            end
            t++;
        end
        if (tx_at[start-1] !== 1'b1 && bad < 0) begin
            bad = 0; bad_got = tx_at[start-1]; bad_exp = 1'b1;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: tx at clock %0d of %0d got %0b expected %0b",
                     name, bad, total, bad_got, bad_exp);
        end else begin
            $display("ok   %s: %0d clocks match", name, total);
        end
        exp_bits.delete();
        exp_lens.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int n0;
        logic idle_ok;

        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1 check("tx_in_reset", {31'b0, tx}, 32'h1);
        @(negedge clk) rst = 1'b0;

        // Register map, decode and qualification
        add_vec(1, 0, A_STATUS,      0,            32'h02 | PAR_FLAG, "status_reset");
        add_vec(1, 0, A_DIVISOR,     0,            32'd16,            "divisor_reset");
        add_vec(1, 0, A_TXDATA,      0,            32'h0,             "txdata_reads0");
        add_vec(1, 0, 32'h0000_100C, 0,            32'h0,             "unmapped_reads0");
        add_vec(1, 0, 32'h0000_2008, 0,            32'h0,             "outrange_reads0");
        add_vec(0, 0, A_DIVISOR,     0,            32'h0,             "ce0_reads0");
        add_vec(1, 1, A_DIVISOR,     32'hABCD_1234, 0,                "wr_div");
        add_vec(1, 0, A_DIVISOR,     0,            32'h1234,          "div_low16");
        add_vec(1, 1, 32'h0000_2008, 32'h5,        0,                 "wr_outrange");
        add_vec(1, 0, A_DIVISOR,     0,            32'h1234,          "div_after_outrange");
        add_vec(0, 1, A_DIVISOR,     32'h7,        0,                 "wr_ce0");
        add_vec(1, 0, 32'h0000_100B, 0,            32'h1234,          "div_after_ce0");
        add_vec(1, 1, 32'h0000_100C, 32'h9,        0,                 "wr_unmapped");
        add_vec(1, 0, A_DIVISOR,     0,            32'h1234,          "div_after_unmapped");
        add_vec(0, 1, A_TXDATA,      32'h55,       0,                 "push_ce0");
        add_vec(1, 1, 32'h0000_3000, 32'h55,       0,                 "push_outrange");
        add_vec(1, 0, A_STATUS,      0,            32'h02 | PAR_FLAG, "no_push_status");
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            ce = vecs[i].ce; we = vecs[i].we; addr = vecs[i].addr; data_i = vecs[i].wdata;
            #1;
            if (!vecs[i].we) check(vecs[i].name, data_o, vecs[i].exp);
            @(posedge clk); #1;
            ce = 1'b0; we = 1'b0; addr = '0; data_i = '0;
        end

        // Single frame 0xA5 at divisor 4, with STATUS timing around it
        bus_write(A_DIVISOR, 32'd4);
        bus_write(A_TXDATA, 32'hA5);
        n0 = edge_cnt;
        bus_read(A_STATUS, rd);
        check("status_after_push", rd, 32'h12 & 32'h10 | PAR_FLAG);
        bus_read(A_STATUS, rd);
        check("status_after_pop", rd, 32'h06 | PAR_FLAG);
        add_frame(8'hA5, 4);
        wait_edge(n0 + FB * 4);
        bus_read(A_STATUS, rd);
        check("busy_in_stop", rd, 32'h06 | PAR_FLAG);
        bus_read(A_STATUS, rd);
        check("busy_cleared", rd, 32'h02 | PAR_FLAG);
        check_wave("frame_A5_div4", n0 + 1);

        // Parity-relevant byte
        bus_write(A_DIVISOR, 32'd3);
        bus_write(A_TXDATA, 32'h07);
        n0 = edge_cnt;
        add_frame(8'h07, 3);
        check_wave("frame_07_div3", n0 + 1);

        // Overflow: five bytes fit (one is popped at once), the sixth is dropped
        bus_write(A_DIVISOR, 32'd2);
        bus_write(A_TXDATA, 32'h01);
        n0 = edge_cnt;
        for (int b = 2; b <= 6; b++) bus_write(A_TXDATA, 32'(b));
        bus_read(A_STATUS, rd);
        check("status_overflow", rd, 32'h4D | PAR_FLAG);
        bus_write(A_STATUS, 32'h0);
        bus_read(A_STATUS, rd);
        check("overflow_cleared", rd, 32'h45 | PAR_FLAG);
        for (int b = 1; b <= 5; b++) add_frame(8'(b), 2);
        check_wave("back_to_back_div2", n0 + 1);

        // Divisor 4 -> 8 committed mid DATA bit 1; that bit keeps 4 clocks
        bus_write(A_DIVISOR, 32'd4);
        bus_write(A_TXDATA, 32'h3C);
        n0 = edge_cnt;
        wait_edge(n0 + 9);
        bus_write(A_DIVISOR, 32'd8);
        add_frame(8'h3C, 8);
        for (int k = 0; k < 3; k++) exp_lens[k] = 4;
        check_wave("div_change_mid_frame", n0 + 1);

        // Reset during DATA bit 3 of 0xFF with two more bytes queued
        bus_write(A_DIVISOR, 32'd4);
        bus_write(A_TXDATA, 32'hFF);
        n0 = edge_cnt;
        bus_write(A_TXDATA, 32'h11);
        bus_write(A_TXDATA, 32'h22);
        wait_edge(n0 + 17);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("tx_at_reset_edge", {31'b0, tx}, 32'h1);
        @(negedge clk) rst = 1'b0;
        bus_read(A_STATUS, rd);
        check("status_after_reset", rd, 32'h02 | PAR_FLAG);
        bus_read(A_DIVISOR, rd);
        check("divisor_after_reset", rd, 32'd16);
        n0 = edge_cnt;
        wait_edge(n0 + 400);
        idle_ok = 1'b1;
        for (int e = n0; e < n0 + 400; e++) if (tx_at[e] !== 1'b1) idle_ok = 1'b0;
        check("no_frame_after_reset", {31'b0, idle_ok}, 32'h1);

        // Randomized bursts against the bit-stream model
        for (int it = 0; it < 12; it++) begin
            int div;
            int n;
            logic [7:0] b;
            div = int'($urandom_range(0, 4));
            n   = int'($urandom_range(1, 4));
            bus_write(A_DIVISOR, 32'(div));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                bus_write(A_TXDATA, {24'($urandom), b});
                if (k == 0) n0 = edge_cnt;
                add_frame(b, (div == 0) ? 1 : div);
            end
            $display("rand %0d: divisor=%0d bytes=%0d", it, div, n);
            check_wave($sformatf("rand_burst_%0d", it), n0 + 1);
            bus_read(A_STATUS, rd);
            check($sformatf("rand_status_%0d", it), rd, 32'h02 | PAR_FLAG);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
